// File: rtl/rgb_led_pwm_ctrl_if.sv
// Avalon-MM slave bus bundle for rgb_led_pwm_ctrl.
//
// Handshake: a transfer completes on every rising clk edge where avs_write
// or avs_read is high. There is no waitrequest, so the slave is always
// ready. avs_readdata is valid exactly one cycle after the avs_read cycle
// and reads 0 on cycles that follow no read.
interface rgb_led_pwm_ctrl_if;
  logic [3:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address,
    output avs_write,
    output avs_writedata,
    output avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_write,
    input  avs_writedata,
    input  avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/rgb_led_pwm_ctrl.sv
// rgb_led_pwm_ctrl: NUM_LEDS RGB LEDs driven by per-colour PWM with
// double-buffered duty registers and per-LED blink, behind one Avalon-MM
// slave.
//
// Register map (word addresses):
//   0      CTRL      [0] enable (RW), [1] blink_phase (RO)
//   1      PRESCALE  [15:0]
//   2      BLINK     [15:0] blink_len in PWM periods, [16 +: NUM_LEDS] blink enables
//   3+i    DUTYi     R [0 +: PWM_BITS], G [8 +: PWM_BITS], B [16 +: PWM_BITS]
//
// Optional build macro RGB_LED_PWM_CTRL_FADE_EN: at each period boundary
// every active duty steps by one toward its shadow instead of being copied.
module rgb_led_pwm_ctrl #(
  parameter int NUM_LEDS   = 4,
  parameter int PWM_BITS   = 8,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  rgb_led_pwm_ctrl_if.slave       avs,
  output logic [3*NUM_LEDS-1:0]   led_out
);

  localparam logic                INACTIVE = (ACTIVE_LOW != 0);
  localparam logic [PWM_BITS-1:0] PWM_ONE  = 1;
  // Last counter value of a period: MAX-1 = 2^PWM_BITS - 2.
  localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [15:0]         CNT_ONE  = 16'd1;

  // Programmable state
  logic                enable;
  logic [15:0]         prescale;
  logic [15:0]         blink_len;
  logic [NUM_LEDS-1:0] blink_en;
  logic [PWM_BITS-1:0] shadow_duty [NUM_LEDS][3];

  // Running state
  logic [15:0]         pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [15:0]         blink_cnt;
  logic                blink_phase;
  logic [PWM_BITS-1:0] active_duty [NUM_LEDS][3];

  // Decode / datapath nets
  logic                wr_ctrl;
  logic                wr_prescale;
  logic                wr_blink;
  logic [NUM_LEDS-1:0] wr_duty;
  logic                tick;
  logic                boundary;
  logic [16:0]         blink_cnt_inc;
  logic [31:0]         rd_mux;
  logic [3*NUM_LEDS-1:0] led_next;
  logic                unused_wdata;

  // Upper write-data bits that map to no register are ignored.
  assign unused_wdata = ^avs.avs_writedata;

  // Write strobes for the fixed registers.
  assign wr_ctrl     = avs.avs_write && (avs.avs_address == 4'd0);
  assign wr_prescale = avs.avs_write && (avs.avs_address == 4'd1);
  assign wr_blink    = avs.avs_write && (avs.avs_address == 4'd2);

  // Write strobes for the per-LED duty registers at 3..3+NUM_LEDS-1.
  always_comb begin
    wr_duty = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (avs.avs_write && (avs.avs_address == 4'(i + 3))) begin
        wr_duty[i] = 1'b1;
      end
    end
  end

  // Prescaler tick; >= so that lowering PRESCALE below pre_cnt ticks at once.
  assign tick     = enable && (pre_cnt >= prescale);
  assign boundary = tick && (pwm_cnt == PWM_LAST);

  assign blink_cnt_inc = {1'b0, blink_cnt} + {1'b0, CNT_ONE};

  // Bus-writable control registers and duty shadows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable    <= 1'b0;
      prescale  <= '0;
      blink_len <= '0;
      blink_en  <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        for (int c = 0; c < 3; c++) begin
          shadow_duty[i][c] <= '0;
        end
      end
    end else begin
      if (wr_ctrl) begin
        enable <= avs.avs_writedata[0];
      end
      if (wr_prescale) begin
        prescale <= avs.avs_writedata[15:0];
      end
      if (wr_blink) begin
        blink_len <= avs.avs_writedata[15:0];
        blink_en  <= avs.avs_writedata[16 +: NUM_LEDS];
      end
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (wr_duty[i]) begin
          for (int c = 0; c < 3; c++) begin
            shadow_duty[i][c] <= avs.avs_writedata[8*c +: PWM_BITS];
          end
        end
      end
    end
  end

  // Prescaler and PWM counter; both parked at 0 while disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (!enable) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : (pre_cnt + CNT_ONE);
      if (tick) begin
        pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : (pwm_cnt + PWM_ONE);
      end
    end
  end

  // Blink period counter and phase; phase held at 1 when idle or blink_len is 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (!enable || (blink_len == 16'd0)) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (boundary) begin
      // >= rather than == so that shrinking blink_len cannot strand the counter.
      if (blink_cnt_inc >= {1'b0, blink_len}) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt_inc[15:0];
      end
    end
  end

  // Active duties: follow shadow while disabled, otherwise update only at a
  // period boundary so a running period never sees a partial change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        for (int c = 0; c < 3; c++) begin
          active_duty[i][c] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        for (int c = 0; c < 3; c++) begin
          if (!enable) begin
            active_duty[i][c] <= shadow_duty[i][c];
          end else if (boundary) begin
`ifdef RGB_LED_PWM_CTRL_FADE_EN
            if (active_duty[i][c] < shadow_duty[i][c]) begin
              active_duty[i][c] <= active_duty[i][c] + PWM_ONE;
            end else if (active_duty[i][c] > shadow_duty[i][c]) begin
              active_duty[i][c] <= active_duty[i][c] - PWM_ONE;
            end
`else
            active_duty[i][c] <= shadow_duty[i][c];
`endif
          end
        end
      end
    end
  end

  // Channel compare, blink masking and pin polarity.
  always_comb begin
    led_next = {(3*NUM_LEDS){INACTIVE}};
    for (int i = 0; i < NUM_LEDS; i++) begin
      for (int c = 0; c < 3; c++) begin
        led_next[3*i + c] = (enable
                             && !(blink_en[i] && !blink_phase)
                             && (active_duty[i][c] > pwm_cnt)) ^ INACTIVE;
      end
    end
  end

  // Registered pins; reset forces the inactive level asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out <= {(3*NUM_LEDS){INACTIVE}};
    end else begin
      led_out <= led_next;
    end
  end

  // Read multiplexer; unmapped addresses and unused bits read 0.
  always_comb begin
    rd_mux = '0;
    case (avs.avs_address)
      4'd0: rd_mux[1:0] = {blink_phase, enable};
      4'd1: rd_mux[15:0] = prescale;
      4'd2: begin
        rd_mux[15:0]           = blink_len;
        rd_mux[16 +: NUM_LEDS] = blink_en;
      end
      default: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          if (avs.avs_address == 4'(i + 3)) begin
            for (int c = 0; c < 3; c++) begin
              rd_mux[8*c +: PWM_BITS] = shadow_duty[i][c];
            end
          end
        end
      end
    endcase
  end

  // Read data register: fixed one-cycle latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avs.avs_readdata <= '0;
    end else begin
      avs.avs_readdata <= avs.avs_read ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_rgb_led_pwm_ctrl.sv
// Directed testbench for rgb_led_pwm_ctrl (NUM_LEDS=4, PWM_BITS=8), with a
// second ACTIVE_LOW=1 instance for the inverted reset level.
module tb_rgb_led_pwm_ctrl;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rgb_led_pwm_ctrl_if bus ();
  rgb_led_pwm_ctrl_if bus_al ();
  logic [11:0] led_out;
  logic [11:0] led_out_al;

  rgb_led_pwm_ctrl #(.NUM_LEDS(4), .PWM_BITS(8), .ACTIVE_LOW(0)) dut (
    .clk(clk), .reset(reset), .avs(bus.slave), .led_out(led_out)
  );

  rgb_led_pwm_ctrl #(.NUM_LEDS(4), .PWM_BITS(8), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .reset(reset), .avs(bus_al.slave), .led_out(led_out_al)
  );

  // Scoreboard counters
  int n_vec = 0;
  int n_err = 0;

  // Pin monitor: high-cycle and rising-edge counts per led_out bit,
  // sampled 2 ns after every rising clk edge.
  int hi_cnt [12];
  int rise_cnt [12];
  int hi_base [12];
  int rise_base [12];
  logic [11:0] prev_led = '0;

  initial begin
    for (int b = 0; b < 12; b++) begin
      hi_cnt[b] = 0;
      rise_cnt[b] = 0;
      hi_base[b] = 0;
      rise_base[b] = 0;
    end
  end

  always @(posedge clk) begin
    #2;
    for (int b = 0; b < 12; b++) begin
      if (led_out[b]) hi_cnt[b]++;
      if (led_out[b] && !prev_led[b]) rise_cnt[b]++;
    end
    prev_led = led_out;
  end

  task automatic snap();
    for (int b = 0; b < 12; b++) begin
      hi_base[b] = hi_cnt[b];
      rise_base[b] = rise_cnt[b];
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_hi(input string tag, input int b, input int exp);
    check(tag, 32'(hi_cnt[b] - hi_base[b]), 32'(exp));
  endtask

  task automatic check_rise(input string tag, input int b, input int exp);
    check(tag, 32'(rise_cnt[b] - rise_base[b]), 32'(exp));
  endtask

  // Driver tasks
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.avs_address = a;
    bus.avs_writedata = d;
    bus.avs_write = 1'b1;
    @(negedge clk);
    bus.avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.avs_address = a;
    bus.avs_read = 1'b1;
    @(negedge clk);
    bus.avs_read = 1'b0;
    d = bus.avs_readdata;
  endtask

  logic [31:0] rd;

  initial begin
    bus.avs_address = '0;
    bus.avs_write = 1'b0;
    bus.avs_writedata = '0;
    bus.avs_read = 1'b0;
    bus_al.avs_address = '0;
    bus_al.avs_write = 1'b0;
    bus_al.avs_writedata = '0;
    bus_al.avs_read = 1'b0;

    // Reset state
    #12;
    check("reset_led", 32'(led_out), 32'h000);
    check("reset_led_al", 32'(led_out_al), 32'hFFF);
    @(negedge clk);
    reset = 1'b0;
    bus_read(4'd0, rd);
    check("reset_ctrl", rd, 32'h2);
    for (int i = 0; i < 4; i++) begin
      bus_read(4'(i + 3), rd);
      check("reset_duty", rd, 32'h0);
    end
    check("idle_led_al", 32'(led_out_al), 32'hFFF);

    // Register widths and unmapped addresses
    bus_write(4'd1, 32'hFFFF_1234);
    bus_read(4'd1, rd);
    check("prescale_rb", rd, 32'h0000_1234);
    bus_write(4'd2, 32'hFFFF_FFFF);
    bus_read(4'd2, rd);
    check("blink_rb", rd, 32'h000F_FFFF);
    bus_write(4'd3, 32'hFFFF_FFFF);
    bus_read(4'd3, rd);
    check("duty0_rb", rd, 32'h00FF_FFFF);
    bus_write(4'd7, 32'hDEAD_BEEF);
    bus_read(4'd7, rd);
    check("unmapped7_rb", rd, 32'h0);
    bus_read(4'd15, rd);
    check("unmapped15_rb", rd, 32'h0);
    check("disabled_led", 32'(led_out), 32'h000);
    bus_write(4'd1, 32'h0);
    bus_write(4'd2, 32'h0);

    // Duty waveform: PRESCALE=0, period 255 clk
    bus_write(4'd3, 32'h0000_FF80);
    bus_write(4'd0, 32'h1);
    snap();
    wait_n(255);
    check_hi("wave_r0_hi", 0, 128);
    check_hi("wave_g0_hi", 1, 255);
    check_hi("wave_b0_hi", 2, 0);
    check_hi("wave_r1_hi", 3, 0);
    bus_read(4'd0, rd);
    check("ctrl_enabled", rd, 32'h3);

    // Double buffer on DUTY1 R
    bus_write(4'd0, 32'h0);
    bus_write(4'd4, 32'h0000_00F0);
    bus_write(4'd0, 32'h1);
    snap();
    wait_n(255);
    check_hi("dbuf_p1_r1", 3, 240);
    check_hi("dbuf_p1_r0", 0, 128);
    snap();
    wait_n(50);
    bus_write(4'd4, 32'h0000_0010);
    wait_n(203);
    check_hi("dbuf_p2_r1", 3, 240);
    check_rise("dbuf_p2_rise", 3, 1);
    snap();
    wait_n(255);
    check_hi("dbuf_p3_r1", 3, 16);
    check_rise("dbuf_p3_rise", 3, 1);

    // Blink: LED0 blink-enabled, blink_len 2; LED1 not blink-enabled
    bus_write(4'd0, 32'h0);
    bus_write(4'd3, 32'h0000_00FF);
    bus_write(4'd4, 32'h0000_00FF);
    bus_write(4'd2, 32'h0001_0002);
    bus_write(4'd0, 32'h1);
    snap();
    wait_n(255);
    check_hi("blink_p1_r0", 0, 255);
    snap();
    wait_n(100);
    bus_read(4'd0, rd);
    check("blink_p2_ctrl", rd, 32'h3);
    wait_n(153);
    check_hi("blink_p2_r0", 0, 255);
    snap();
    wait_n(100);
    bus_read(4'd0, rd);
    check("blink_p3_ctrl", rd, 32'h1);
    wait_n(153);
    check_hi("blink_p3_r0", 0, 0);
    check_hi("blink_p3_r1", 3, 255);
    snap();
    wait_n(255);
    check_hi("blink_p4_r0", 0, 0);
    snap();
    wait_n(255);
    check_hi("blink_p5_r0", 0, 255);
    check_rise("blink_p5_rise", 0, 1);

    // Prescale change 100 -> 10 while pre_cnt is 50
    bus_write(4'd0, 32'h0);
    bus_write(4'd2, 32'h0);
    bus_write(4'd1, 32'd100);
    bus_write(4'd3, 32'h1);
    bus_write(4'd4, 32'h2);
    bus_write(4'd5, 32'h3);
    bus_write(4'd6, 32'h0);
    bus_write(4'd0, 32'h1);
    snap();
    wait_n(49);
    bus_write(4'd1, 32'd10);
    wait_n(99);
    check_hi("presc_r0_hi", 0, 52);
    check_hi("presc_r1_hi", 3, 63);
    check_hi("presc_r2_hi", 6, 74);
    check_hi("presc_r3_hi", 9, 0);

    // Disable mid-operation, then re-enable from pwm_cnt 0
    bus_write(4'd0, 32'h0);
    bus_write(4'd1, 32'h0);
    bus_write(4'd3, 32'h00FF_FFFF);
    bus_write(4'd4, 32'h0);
    bus_write(4'd5, 32'h0);
    bus_write(4'd0, 32'h1);
    wait_n(5);
    check("full_on_led", 32'(led_out), 32'h007);
    bus_write(4'd0, 32'h0);
    wait_n(1);
    check("disable_led", 32'(led_out), 32'h000);
    bus_write(4'd3, 32'h0000_0080);
    bus_write(4'd0, 32'h1);
    snap();
    wait_n(128);
    check_hi("reen_first_r0", 0, 128);
    check_hi("reen_first_g0", 1, 0);
    snap();
    wait_n(127);
    check_hi("reen_second_r0", 0, 0);

    // Asynchronous reset pulse between clock edges
    bus_write(4'd0, 32'h0);
    bus_write(4'd3, 32'h00FF_FFFF);
    bus_write(4'd0, 32'h1);
    wait_n(3);
    check("pre_reset_led", 32'(led_out), 32'h007);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_led", 32'(led_out), 32'h000);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_led", 32'(led_out), 32'h000);
    bus_read(4'd0, rd);
    check("post_reset_ctrl", rd, 32'h2);
    bus_read(4'd3, rd);
    check("post_reset_duty0", rd, 32'h0);
    bus_read(4'd1, rd);
    check("post_reset_prescale", rd, 32'h0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rgb_led_pwm_ctrl.md
Name: rgb_led_pwm_ctrl

Overview:
- Parametrised successor to the fabric PIO LED outputs (rgb_led*, niosv_rgb_led*).
- Drives NUM_LEDS RGB LEDs from one Avalon-MM slave, with per-colour PWM brightness, glitch-free double-buffered duty updates and per-LED blink.
- Sits in the platform system on the Nios V / HPS lightweight bus; its led_out bus goes to the board LED pins in place of plain PIO exports.

Parameters:
- NUM_LEDS, 4, number of RGB LEDs; 1..13.
- PWM_BITS, 8, duty resolution per colour; 2..8.
- ACTIVE_LOW, 0, 1 = LED on when pin low; sets the inactive/reset level of led_out.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- avs_address  in  4  word address.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data, valid 1 cycle after avs_read.
- led_out  out  3*NUM_LEDS  LED i: bit 3i = R, bit 3i+1 = G, bit 3i+2 = B.

Behaviour:
- Register map (word addresses):
  - 0 CTRL: [0] enable (RW); [1] blink_phase (RO).
  - 1 PRESCALE: [15:0] (RW).
  - 2 BLINK: [15:0] blink_len in PWM periods (RW); [16+NUM_LEDS-1:16] per-LED blink enable (RW).
  - 3+i DUTYi: R [PWM_BITS-1:0], G [8+PWM_BITS-1:8], B [16+PWM_BITS-1:16]. Writes go to shadow; reads return shadow.
- Unmapped addresses: writes ignored, reads return 0. Unused bits read 0. Read latency is fixed at 1 and there is no waitrequest.
- Reset: all registers, counters and shadow/active duties are 0. blink_phase = 1. led_out = all bits ACTIVE_LOW (inactive).
- Prescaler:
  - pre_cnt counts up each clk. When pre_cnt >= PRESCALE, tick = 1 and pre_cnt <= 0.
  - PRESCALE = 0 gives a tick every cycle.
  - Lowering PRESCALE below the current pre_cnt gives a tick on the next cycle. No lockup.
- PWM counter:
  - MAX = 2^PWM_BITS - 1. pwm_cnt advances on tick over 0..MAX-1, then wraps to 0.
  - Period = MAX ticks = (PRESCALE+1)*MAX clk.
- Period boundary = tick && pwm_cnt == MAX-1. On that cycle:
  - pwm_cnt <= 0.
  - active duty <= shadow duty (all colours, all LEDs, atomically).
  - blink counter updates.
- Channel compare: on = (active_duty > pwm_cnt). Duty 0 is never on; duty MAX is always on; duty d is on for d ticks per period.
- led_out is registered, 1 clk after the compare inputs. Pin = on XOR ACTIVE_LOW.
- Blink:
  - blink_len = 0: blink_phase is held at 1.
  - Otherwise a period counter increments at each boundary. When it reaches blink_len, blink_phase toggles and the counter clears.
  - A blink-enabled LED with blink_phase = 0 is forced off on all three colours.
- enable = 0:
  - led_out is held inactive.
  - pre_cnt, pwm_cnt and the blink counter are held at 0; blink_phase = 1.
  - Active duty tracks shadow every cycle, so the new duty is in effect on the first enabled cycle.
- A write to DUTYi on the same cycle as a boundary lands in shadow after the copy, so it takes effect at the next boundary.
- Reset asserted mid-period: everything returns to reset values immediately, and led_out goes inactive without waiting for a clk edge.

Optional Feature:
- Macro: RGB_LED_PWM_CTRL_FADE_EN.
- Defined: at each boundary every active duty steps by 1 toward its shadow instead of being copied. A full 0 -> MAX fade takes MAX periods; it stops when equal. While enable = 0, active still tracks shadow directly.
- Undefined: direct copy at the boundary, exactly as described in Behaviour.

Test Plan:
- Reset:
  - ACTIVE_LOW=0: led_out == 0, CTRL reads 0x2, all DUTY read 0.
  - ACTIVE_LOW=1: led_out all ones.
- Duty waveform:
  - PRESCALE=0, DUTY0=0x0000FF80, enable=1 -> R0 high 128 of every 255 clk; G0 always on (0xFF); B0 never on.
- Double buffer:
  - Mid-period write DUTY1 R=0x10 (old 0xF0) -> current period finishes at 0xF0; next period shows 16 high clk; no runt pulse.
- Blink:
  - BLINK = 0x0001_0002, DUTY0 R=0xFF -> R0 on for 2 periods, then off for 2 periods, repeating.
  - blink_phase readback matches the on/off pattern.
  - LED1, not blink-enabled, is unaffected.
- Prescale change:
  - PRESCALE=100 with pre_cnt = 50, write PRESCALE=10 -> tick on the next clk; then a tick every 11 clk.
- Disable and reset mid-operation:
  - enable 1->0 -> led_out inactive on the next clk; counters read/observed as 0.
  - Re-enable -> waveform restarts at pwm_cnt 0.
  - Async reset pulse between clk edges -> led_out inactive immediately.
- Fade (macro defined): DUTY0 R 0 -> 0x04 -> active R steps 1,2,3,4 over 4 consecutive boundaries.
